// File: rtl/matmul_abt_seq.sv
// -----------------------------------------------------------------------------
// matmul_abt_seq
// Sequential second-stage matrix multiplier for the Winograd filter-transform
// path. Computes U = A * B^T (A, B are M x L, U is M x M) with a single signed
// multiply-accumulate that is time-multiplexed over M*M*L cycles.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    upstream offers A/B
//   in_ready    block accepts a job (high only while idle)
//   a_mtx       matrix A, row-major, element 0 at MSB, W bits per element
//   b_mtx       matrix B, row-major, element 0 at MSB, W bits per element
//   out_valid   result_mtx holds a completed result
//   out_ready   downstream takes the result
//   result_mtx  U, row-major, element 0 at MSB, OW bits per element
//   busy        high while the MAC loop is running
// -----------------------------------------------------------------------------
module matmul_abt_seq #(
    parameter int W  = 8,
    parameter int M  = 4,
    parameter int L  = 3,
    parameter int OW = 2*W+2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [M*L*W-1:0]  a_mtx,
    input  logic [M*L*W-1:0]  b_mtx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M*M*OW-1:0] result_mtx,
    output logic              busy
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [M*L*W-1:0]    r_a;
    logic [M*L*W-1:0]    r_b;
    logic [IW-1:0]       r_i;
    logic [IW-1:0]       r_j;
    logic [KW-1:0]       r_k;
    logic [OW-1:0]       r_acc;
    logic [OW-1:0]       r_buf [M][M];
    logic [M*M*OW-1:0]   r_result;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_in_ready;

    logic signed [W-1:0]   w_a [M][L];
    logic signed [W-1:0]   w_b [M][L];
    logic signed [W-1:0]   w_a_el;
    logic signed [W-1:0]   w_b_el;
    logic signed [2*W-1:0] w_prod;
    logic [OW-1:0]         w_prod_ext;
    logic [OW-1:0]         w_sum;
    logic [M*M*OW-1:0]     w_buf_pack;
    logic                  w_k_last;
    logic                  w_j_last;
    logic                  w_i_last;

    // Unpack the captured matrices into element arrays (element 0 at MSB).
    for (genvar gr = 0; gr < M; gr++) begin : g_unpack_r
        for (genvar gc = 0; gc < L; gc++) begin : g_unpack_c
            assign w_a[gr][gc] = r_a[(M*L-(gr*L+gc))*W-1 -: W];
            assign w_b[gr][gc] = r_b[(M*L-(gr*L+gc))*W-1 -: W];
        end
    end

    assign w_k_last = (r_k == KW'(L-1));
    assign w_j_last = (r_j == IW'(M-1));
    assign w_i_last = (r_i == IW'(M-1));

    // MAC datapath: full-precision signed product, sign-extended to OW.
    always_comb begin
        w_a_el     = w_a[r_i][r_k];
        w_b_el     = w_b[r_j][r_k];
        w_prod     = w_a_el * w_b_el;
        w_prod_ext = {{(OW-2*W){w_prod[2*W-1]}}, w_prod};
        w_sum      = r_acc + w_prod_ext;
    end

    // Packed view of the buffer with the element finishing this cycle merged
    // in, so the completion edge can publish all M*M results at once.
    for (genvar gi = 0; gi < M; gi++) begin : g_pack_r
        for (genvar gj = 0; gj < M; gj++) begin : g_pack_c
            assign w_buf_pack[(M*M-(gi*M+gj))*OW-1 -: OW] =
                ((r_i == IW'(gi)) && (r_j == IW'(gj))) ? w_sum : r_buf[gi][gj];
        end
    end

    // Control FSM, MAC loop counters, result buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            for (int x = 0; x < M; x++) begin
                for (int y = 0; y < M; y++) begin
                    r_buf[x][y] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a_mtx;
                        r_b        <= b_mtx;
                        r_acc      <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_BUSY;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_k_last) begin
                        // Dot product (i,j) complete: store it and move on.
                        r_buf[r_i][r_j] <= w_sum;
                        r_acc           <= '0;
                        r_k             <= '0;
                        if (w_j_last) begin
                            r_j <= '0;
                            if (w_i_last) begin
                                r_i         <= '0;
                                r_result    <= w_buf_pack;
                                r_out_valid <= 1'b1;
                                r_busy      <= 1'b0;
                                r_state     <= S_DONE;
                            end else begin
                                r_i <= r_i + IW'(1);
                            end
                        end else begin
                            r_j <= r_j + IW'(1);
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_k   <= r_k + KW'(1);
                    end
                end
                S_DONE: begin
                    // in_ready rises only after this edge: no same-cycle re-accept.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign result_mtx = r_result;

endmodule

// File: tb/tb_matmul_abt_seq.sv
// -----------------------------------------------------------------------------
// tb_matmul_abt_seq
// Self-checking bench for matmul_abt_seq: directed jobs, a reference model of
// U = A*B^T computed with plain integer arithmetic, a per-cycle result
// comparator, and literal expectations for a few hand-computed cases.
// -----------------------------------------------------------------------------
module tb_matmul_abt_seq;

    localparam int W  = 8;
    localparam int M  = 4;
    localparam int L  = 3;
    localparam int OW = 2*W+2;
    localparam int AW = M*L*W;
    localparam int RW = M*M*OW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a_mtx;
    logic [AW-1:0] b_mtx;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result_mtx;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [RW-1:0] exp_res = '0;
    bit            exp_armed = 1'b0;

    localparam logic [AW-1:0] A1 = {8'd1, 8'd0, 8'd0,  8'd0, 8'd1, 8'd0,
                                    8'd0, 8'd0, 8'd1,  8'd1, 8'd1, 8'd1};
    localparam logic [RW-1:0] U1 = {18'd1, 18'd0, 18'd0, 18'd1,
                                    18'd0, 18'd1, 18'd0, 18'd1,
                                    18'd0, 18'd0, 18'd1, 18'd1,
                                    18'd1, 18'd1, 18'd1, 18'd3};
    localparam logic [AW-1:0] A2 = {8'd1, 8'd2, 8'd3,  8'd4,  8'd5,  8'd6,
                                    8'd7, 8'd8, 8'd9,  8'd10, 8'd11, 8'd12};
    localparam logic [AW-1:0] AMIN = {12{8'h80}};
    localparam logic [AW-1:0] AMAX = {12{8'h7F}};
    localparam logic [RW-1:0] UMINMIN = {16{18'd49152}};
    localparam logic [RW-1:0] UMINMAX = {16{18'h34180}};  // -48768

    matmul_abt_seq #(.W(W), .M(M), .L(L), .OW(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_mtx      (a_mtx),
        .b_mtx      (b_mtx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_mtx (result_mtx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: U[i][j] = sum_k A[i][k]*B[j][k] in plain integers.
    function automatic logic [RW-1:0] model(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [RW-1:0] r;
        int            s;
        logic [31:0]   sv;
        r = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < M; j++) begin
                s = 0;
                for (int k = 0; k < L; k++) begin
                    s += $signed(a[(M*L-(i*L+k))*W-1 -: W]) * $signed(b[(M*L-(j*L+k))*W-1 -: W]);
                end
                sv = s;
                r[(M*M-(i*M+j))*OW-1 -: OW] = sv[OW-1:0];
            end
        end
        return r;
    endfunction

    function automatic int get_u(input logic [RW-1:0] r, input int i, input int j);
        logic signed [OW-1:0] e;
        e = r[(M*M-(i*M+j))*OW-1 -: OW];
        return int'(e);
    endfunction

    task automatic check_vec(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Every cycle a result is presented, it must match the model of the job in flight.
    always @(negedge clk) begin
        if (!rst && out_valid && exp_armed) begin
            check_vec("stream_result", result_mtx, exp_res);
        end
    end

    task automatic accept(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit keep_valid);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_int("ready_before_accept", int'(in_ready), 1);
        a_mtx    = a;
        b_mtx    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_valid) begin
            in_valid = 1'b0;
            a_mtx    = '0;
            b_mtx    = '0;
        end
        exp_res   = model(a, b);
        exp_armed = 1'b1;
        check_int("busy_after_accept", int'(busy), 1);
        check_int("in_ready_after_accept", int'(in_ready), 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 200);
        check_int("latency", n, M*M*L);
        check_int("busy_at_done", int'(busy), 0);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_int("out_valid_after_hs", int'(out_valid), 0);
        check_int("in_ready_after_hs", int'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [RW-1:0] held;
        logic [RW-1:0] m;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_mtx     = '0;
        b_mtx     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_busy", int'(busy), 0);
        check_vec("reset_result", result_mtx, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_int("in_ready_idle", int'(in_ready), 1);

        // Model pins against hand-computed values.
        check_vec("model_pin_identity", model(A1, A1), U1);
        m = model(A2, A2);
        check_int("model_pin_u00", get_u(m, 0, 0), 14);
        check_int("model_pin_u33", get_u(m, 3, 3), 365);
        check_vec("model_pin_minmax", model(AMIN, AMAX), UMINMAX);

        // Identity-like rows.
        accept(A1, A1, 1'b0);
        wait_done();
        check_vec("t1_result", result_mtx, U1);
        handshake();

        // 1..12 ramp.
        accept(A2, A2, 1'b0);
        wait_done();
        check_int("t2_u00", get_u(result_mtx, 0, 0), 14);
        check_int("t2_u03", get_u(result_mtx, 0, 3), 68);
        check_int("t2_u12", get_u(result_mtx, 1, 2), 122);
        check_int("t2_u33", get_u(result_mtx, 3, 3), 365);
        handshake();

        // Extremes.
        accept(AMIN, AMIN, 1'b0);
        wait_done();
        check_vec("t3_minmin", result_mtx, UMINMIN);
        handshake();

        accept(AMIN, AMAX, 1'b0);
        wait_done();
        check_vec("t3_minmax", result_mtx, UMINMAX);

        // Backpressure with a competing request that must be ignored.
        held = result_mtx;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_vec("bp_result_stable", result_mtx, held);
            check_int("bp_in_ready", int'(in_ready), 0);
            check_int("bp_out_valid", int'(out_valid), 1);
            in_valid = 1'b1;
            a_mtx    = A2;
            b_mtx    = A1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_int("bp_busy", int'(busy), 0);
        handshake();
        @(posedge clk);
        #1;
        check_int("bp_no_capture_busy", int'(busy), 0);
        check_int("bp_no_capture_valid", int'(out_valid), 0);
        check_vec("bp_result_retained", result_mtx, UMINMAX);

        // Reset in the middle of a job.
        accept(A1, A1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rst       = 1'b1;
        exp_armed = 1'b0;
        #1;
        check_int("midrst_out_valid", int'(out_valid), 0);
        check_int("midrst_busy", int'(busy), 0);
        check_vec("midrst_result", result_mtx, '0);
        @(negedge clk);
        rst = 1'b0;
        accept(A2, A2, 1'b0);
        wait_done();
        check_vec("midrst_rerun", result_mtx, model(A2, A2));
        check_int("midrst_rerun_u03", get_u(result_mtx, 0, 3), 68);
        handshake();

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        accept(A1, A2, 1'b1);
        a_mtx = A2;
        b_mtx = A1;
        wait_done();
        check_vec("b2b_first", result_mtx, model(A1, A2));
        @(posedge clk);
        #1;
        check_int("b2b_hs_out_valid", int'(out_valid), 0);
        check_int("b2b_hs_in_ready", int'(in_ready), 1);
        exp_res = model(A2, A1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_int("b2b_second_accept_busy", int'(busy), 1);
        check_int("b2b_second_accept_ready", int'(in_ready), 0);
        wait_done();
        check_vec("b2b_second", result_mtx, model(A2, A1));
        @(posedge clk);
        #1;
        check_int("b2b_final_hs", int'(out_valid), 0);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
